// File: rtl/borrow_lookahead_sub.sv
// Purpose: multi-cycle WIDTH-bit subtractor, diff = a - b - bin, using one 4-bit borrow-lookahead slice per cycle.
// Latency: handshake at edge 0 -> out_valid at edge WIDTH/4; one result every WIDTH/4+2 cycles back-to-back.
// Backpressure: in_ready only in IDLE; result held stable in DONE until out_ready.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid / in_ready operand handshake for a (minuend), b (subtrahend), bin (borrow-in)
//   out_valid/out_ready result handshake for diff ((a-b-bin) mod 2^WIDTH) and bout (a < b+bin)
module borrow_lookahead_sub #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int NSLICE = WIDTH / 4;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] LAST_SLICE = CW'(NSLICE - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;

  // Current slice: operands are shifted right each RUN cycle, so the
  // active slice is always the low nibble.
  logic [3:0] sa, sb, g, p, sd;
  logic [4:0] br;
  logic [WIDTH+3:0] diff_cat;

  assign sa = a_q[3:0];
  assign sb = b_q[3:0];
  assign g  = ~sa & sb;       // generate: this bit borrows on its own
  assign p  = ~(sa ^ sb);     // propagate: equal bits pass the borrow through

  // Flat two-level lookahead; no term depends on another br[] output.
  assign br[0] = br_q;
  assign br[1] = g[0]
               | (p[0] & br_q);
  assign br[2] = g[1]
               | (p[1] & g[0])
               | (p[1] & p[0] & br_q);
  assign br[3] = g[2]
               | (p[2] & g[1])
               | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & br_q);
  assign br[4] = g[3]
               | (p[3] & g[2])
               | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & br_q);

  assign sd = sa ^ sb ^ br[3:0];

  // Result fills from the top; after NSLICE shifts slice 0 lands at bit 0.
  assign diff_cat = {sd, diff_q};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          br_d    = bin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d    = a_q >> 4;
        b_d    = b_q >> 4;
        br_d   = br[4];
        diff_d = diff_cat[WIDTH+3:4];
        if (cnt_q == LAST_SLICE) begin
          // Counter holds at the last slice rather than wrapping.
          bout_d  = br[4];
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign diff      = diff_q;
  assign bout      = bout_q;

endmodule

// File: tb/tb_borrow_lookahead_sub.sv
// Purpose: self-checking bench for borrow_lookahead_sub (WIDTH=16) against an arithmetic reference.
// Latency: expects out_valid exactly NSLICE edges after the input handshake.
// Backpressure: exercises out_ready=0 hold in DONE and in_valid ignored outside IDLE.
module tb_borrow_lookahead_sub;

  localparam int W      = 16;
  localparam int NSLICE = W / 4;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         bout;

  int n_checks = 0;
  int n_errors = 0;

  borrow_lookahead_sub #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain unsigned arithmetic one bit wider than the operands.
  function automatic logic [W:0] ref_sub(input logic [W-1:0] ra, input logic [W-1:0] rb, input logic rbin);
    logic [W:0] r;
    r = {1'b0, ra} - {1'b0, rb} - {{W{1'b0}}, rbin};
    return r;
  endfunction

  // Wait (bounded) for out_valid; called at posedge+1 right after the handshake edge.
  task automatic wait_result(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic check_result(input string tag, input logic [W-1:0] ea, input logic [W-1:0] eb,
                              input logic ebin, input int lat);
    logic [W:0] r;
    r = ref_sub(ea, eb, ebin);
    check({tag, "_lat"},  lat, NSLICE);
    check({tag, "_diff"}, {16'd0, diff}, {16'd0, r[W-1:0]});
    check({tag, "_bout"}, {31'd0, bout}, {31'd0, r[W]});
  endtask

  // Full operation with out_ready held high. Entered and left at posedge+1 in IDLE.
  task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb2, input logic tbin);
    int lat;
    a = ta; b = tb2; bin = tbin; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    // Scramble inputs: result in flight must not depend on them.
    a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
    wait_result(lat);
    check_result(tag, ta, tb2, tbin, lat);
    @(posedge clk); #1;
    check({tag, "_rdy_after"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    logic [W-1:0] ra, rb, na, nb;
    logic         rbin, nbin;
    int           lat;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; bin = 1'b0;
    #12;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("rst_diff",      {16'd0, diff},      32'd0);
    check("rst_bout",      {31'd0, bout},      32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors
    run_op("v1", 16'h1234, 16'h0234, 1'b0);
    run_op("v2", 16'h0000, 16'h0001, 1'b0);
    run_op("v3", 16'h8000, 16'h7FFF, 1'b1);
    run_op("v4", 16'hFFFF, 16'hFFFF, 1'b1);
    run_op("v5", 16'hFFFF, 16'h0000, 1'b0);
    run_op("v6", 16'h0000, 16'hFFFF, 1'b1);

    // Backpressure: hold result while in_valid is asserted with new operands
    ra = 16'hA5C3; rb = 16'h3C5A; rbin = 1'b1;
    na = 16'h0F00; nb = 16'h00F1; nbin = 1'b0;
    out_ready = 1'b0;
    a = ra; b = rb; bin = rbin; in_valid = 1'b1;
    @(posedge clk); #1;
    a = na; b = nb; bin = nbin;       // in_valid stays high during RUN/DONE
    wait_result(lat);
    check_result("bp", ra, rb, rbin, lat);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("bp_hold_vld", {31'd0, out_valid}, 32'd1);
      check("bp_hold_rdy", {31'd0, in_ready},  32'd0);
      check_result("bp_hold", ra, rb, rbin, NSLICE);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_vld", {31'd0, out_valid}, 32'd0);
    check("bp_release_rdy", {31'd0, in_ready},  32'd1);
    @(posedge clk); #1;               // handshake with the new operands
    in_valid = 1'b0;
    wait_result(lat);
    check_result("bp_next", na, nb, nbin, lat);
    @(posedge clk); #1;

    // Reset in the middle of RUN
    a = 16'hBEEF; b = 16'h1234; bin = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;               // two slices processed
    rst_n = 1'b0;
    #1;
    check("mid_rst_vld",  {31'd0, out_valid}, 32'd0);
    check("mid_rst_rdy",  {31'd0, in_ready},  32'd1);
    check("mid_rst_diff", {16'd0, diff},      32'd0);
    check("mid_rst_bout", {31'd0, bout},      32'd0);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_vld", {31'd0, out_valid}, 32'd0);
    run_op("post_rst", 16'h0010, 16'h0001, 1'b0);

    // Randomized back-to-back traffic against the reference
    for (int n = 0; n < 10000; n++) begin
      ra   = W'($urandom);
      rb   = (n % 8 == 0) ? ra : W'($urandom);   // equal operands stress long propagate chains
      rbin = 1'($urandom);
      run_op("rnd", ra, rb, rbin);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
